// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge
//   AXI slave that services one read or write burst at a time from a
//   single-port synchronous SRAM with a one-cycle read latency.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   ar* / r*             AXI read address / read data channels
//   aw* / w* / b*        AXI write address / write data / write response
//   sram_en              SRAM access strobe
//   sram_we              per-byte write enables (all zero = read)
//   sram_addr            SRAM word address
//   sram_wdata           SRAM write data
//   sram_rdata           SRAM read data, valid the cycle after a read strobe
module axi_sram_bridge #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int ID_WIDTH        = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // read address
  input  logic [ID_WIDTH-1:0]         arid,
  input  logic [31:0]                 araddr,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  // read data
  output logic [ID_WIDTH-1:0]         rid,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  // write address
  input  logic [ID_WIDTH-1:0]         awid,
  input  logic [31:0]                 awaddr,
  input  logic [7:0]                  awlen,
  input  logic [2:0]                  awsize,
  input  logic [1:0]                  awburst,
  input  logic                        awvalid,
  output logic                        awready,
  // write data
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  // write response
  output logic [ID_WIDTH-1:0]         bid,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  // SRAM
  output logic                        sram_en,
  output logic [AXI_DATA_WIDTH/8-1:0] sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0]  sram_addr,
  output logic [AXI_DATA_WIDTH-1:0]   sram_wdata,
  input  logic [AXI_DATA_WIDTH-1:0]   sram_rdata
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t                      state_reg, state_next;
  logic [ID_WIDTH-1:0]         id_reg;
  logic [SRAM_ADDR_WIDTH-1:0]  addr_reg;
  logic [7:0]                  len_reg;
  logic [7:0]                  beat_reg;
  logic                        incr_reg;
  logic                        prefer_write_reg;
  logic                        err_reg;
  logic                        rvalid_reg;
  logic                        rlast_reg;
  logic [ID_WIDTH-1:0]         rid_reg;
  logic [AXI_DATA_WIDTH-1:0]   rdata_reg;
  logic                        rd_fresh_reg;

  logic grant_write, grant_read;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic last_beat;
  logic [SRAM_ADDR_WIDTH-1:0] addr_step;

  // Size, low address bits and address bits above the SRAM range play no part.
  logic unused_bits;
  assign unused_bits = ^{arsize, awsize, araddr[31:SRAM_ADDR_WIDTH+2], araddr[1:0],
                         awaddr[31:SRAM_ADDR_WIDTH+2], awaddr[1:0]};

  // On a tie the channel that was not granted last wins.
  assign grant_write = awvalid && (!arvalid || prefer_write_reg);
  assign grant_read  = arvalid && !grant_write;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign r_hs  = rvalid_reg && rready;
  assign b_hs  = bvalid && bready;

  assign last_beat = (beat_reg == len_reg);
  // FIXED and WRAP hold the address; only INCR advances it.
  assign addr_step = addr_reg + {{(SRAM_ADDR_WIDTH-1){1'b0}}, incr_reg};

  assign rvalid = rvalid_reg;
  assign rlast  = rlast_reg;
  assign rid    = rid_reg;
  assign rresp  = 2'b00;
  // The SRAM output is live on the first RD_DATA cycle; after that the
  // captured copy keeps rdata stable for as long as rready stays low.
  assign rdata  = rd_fresh_reg ? sram_rdata : rdata_reg;

  // ---------------- state register ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (aw_hs)      state_next = WR_DATA;
        else if (ar_hs) state_next = RD_REQ;
      end
      RD_REQ:  state_next = RD_DATA;
      RD_DATA: if (r_hs) state_next = rlast_reg ? IDLE : RD_REQ;
      WR_DATA: if (w_hs && last_beat) state_next = WR_RESP;
      WR_RESP: if (bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    bid        = '0;
    bresp      = 2'b00;
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_reg)
      IDLE: begin
        arready = grant_read;
        awready = grant_write;
      end
      RD_REQ: begin
        sram_en   = 1'b1;
        sram_addr = addr_reg;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en    = 1'b1;
          sram_we    = wstrb;
          sram_addr  = addr_reg;
          sram_wdata = wdata;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bid    = id_reg;
        bresp  = err_reg ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      id_reg           <= '0;
      addr_reg         <= '0;
      len_reg          <= '0;
      beat_reg         <= '0;
      incr_reg         <= 1'b0;
      prefer_write_reg <= 1'b1;
      err_reg          <= 1'b0;
      rvalid_reg       <= 1'b0;
      rlast_reg        <= 1'b0;
      rid_reg          <= '0;
      rdata_reg        <= '0;
      rd_fresh_reg     <= 1'b0;
    end else begin
      rd_fresh_reg <= 1'b0;

      if (aw_hs) begin
        id_reg           <= awid;
        addr_reg         <= awaddr[SRAM_ADDR_WIDTH+1:2];
        len_reg          <= awlen;
        incr_reg         <= (awburst == 2'b01);
        beat_reg         <= '0;
        err_reg          <= 1'b0;
        prefer_write_reg <= 1'b0;
      end else if (ar_hs) begin
        id_reg           <= arid;
        addr_reg         <= araddr[SRAM_ADDR_WIDTH+1:2];
        len_reg          <= arlen;
        incr_reg         <= (arburst == 2'b01);
        beat_reg         <= '0;
        prefer_write_reg <= 1'b1;
      end

      if (state_reg == RD_REQ) begin
        rvalid_reg   <= 1'b1;
        rlast_reg    <= last_beat;
        rid_reg      <= id_reg;
        rd_fresh_reg <= 1'b1;
      end

      if (rd_fresh_reg) rdata_reg <= sram_rdata;

      if (r_hs) begin
        rvalid_reg <= 1'b0;
        rlast_reg  <= 1'b0;
        if (!rlast_reg) begin
          addr_reg <= addr_step;
          beat_reg <= beat_reg + 8'd1;
        end
      end

      if (w_hs) begin
        // wlast must coincide exactly with the final beat.
        if (wlast != last_beat) err_reg <= 1'b1;
        addr_reg <= addr_step;
        beat_reg <= beat_reg + 8'd1;
      end

      if (b_hs) err_reg <= 1'b0;
    end
  end

endmodule

// File: doc/axi_sram_bridge.md
Name: axi_sram_bridge

Overview:
- AXI slave that terminates the CPU top-level AXI master port and services it from a single-port synchronous SRAM with 1-cycle read latency.
- Sits directly downstream of the CPU top in SoC and simulation builds, on the AXI bus it drives.
- Handles one transaction at a time, read or write, with INCR-style bursts of up to 256 beats.

Parameters:
- AXI_DATA_WIDTH, 32: AXI and SRAM data width in bits. Byte lanes = AXI_DATA_WIDTH/8.
- SRAM_ADDR_WIDTH, 16: SRAM word-address width.
- ID_WIDTH, 4: AXI ID width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/32/8/3/2  read address channel
- arvalid  in  1;  arready  out  1
- rid/rdata/rresp/rlast  out  ID_WIDTH/AXI_DATA_WIDTH/2/1  read data channel
- rvalid  out  1;  rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/32/8/3/2  write address channel
- awvalid  in  1;  awready  out  1
- wdata/wstrb/wlast  in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1  write data channel
- wvalid  in  1;  wready  out  1
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid  out  1;  bready  in  1
- sram_en  out  1  SRAM access strobe
- sram_we  out  AXI_DATA_WIDTH/8  byte write enables
- sram_addr  out  SRAM_ADDR_WIDTH  word address
- sram_wdata  out  AXI_DATA_WIDTH  write data
- sram_rdata  in  AXI_DATA_WIDTH  read data, valid the cycle after sram_en with sram_we=0

Behaviour:
- Clock and reset: all state is sampled on the rising edge of aclk. aresetn=0 at an edge resets the block.
- Reset values: FSM=IDLE. arready, awready, wready, rvalid, bvalid, rlast, sram_en = 0. sram_we=0. rdata, rid, bid, rresp, bresp, sram_addr, sram_wdata = 0. Tie-break flag = write-first.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE grant: if only arvalid, grant read; if only awvalid, grant write. If both, the channel not granted last wins; after reset, write wins.
- IDLE address accept: in IDLE, arready (or awready) is asserted combinationally for the granted channel only. On handshake, latch id, addr[SRAM_ADDR_WIDTH+1:2] and len, clear the beat counter, and go to RD_REQ (or WR_DATA).
- Address handling: araddr/awaddr bits [1:0] and bits above SRAM_ADDR_WIDTH+1 are ignored. arsize/awsize are ignored.
- Address increment: +1 word per beat, wrapping modulo 2^SRAM_ADDR_WIDTH. For burst types FIXED and WRAP the address is held constant across beats. INCR increments.
- RD_REQ (one cycle): sram_en=1, sram_we=0, sram_addr=current word; then go to RD_DATA.
- RD_DATA entry: on entry edge, rdata<=sram_rdata, rvalid<=1, rlast<=(beat==len), rresp=OKAY(00), rid=latched id.
- RD_DATA hold: rvalid/rdata/rlast are held stable until rready.
- RD_DATA handshake: on rvalid&rready, clear rvalid. If rlast, go to IDLE; else increment address and beat, go to RD_REQ.
- Read throughput: one beat per 2 cycles.
- WR_DATA: wready=1. On wvalid&wready, in the same cycle drive sram_en=1, sram_we=wstrb, sram_addr=current word, sram_wdata=wdata. Then increment address and beat.
- WR_DATA error flag: set if wlast=1 on a beat other than beat==len, or wlast=0 on beat==len.
- WR_DATA exit: after accepting beat==len, go to WR_RESP; wready drops the following cycle. Exactly len+1 beats are written regardless of wlast.
- WR_RESP: bvalid=1, bid=latched id, bresp=SLVERR(10) if the error flag is set, else OKAY(00). Hold until bready, then clear bvalid and the error flag and go to IDLE.
- No outstanding overlap: while busy, arready=awready=0. A pending arvalid/awvalid waits in IDLE.
- Write data arriving before the aw handshake is not accepted: wready=0 outside WR_DATA.
- Reset mid-transaction: the burst is abandoned with no r/b response. SRAM writes already performed remain.

Test Plan:
- Single write then read: awaddr=0x100, awlen=0, wdata=0xDEADBEEF, wstrb=F -> bresp=00 and sram word 0x40 written. Then arlen=0 -> rdata=0xDEADBEEF, rlast=1, rid=arid.
- INCR burst: awaddr=0x200, awlen=3, data 1..4 -> words 0x80..0x83 written. Read back with arlen=3 -> 4 beats 1..4, rlast only on the 4th beat.
- Simultaneous arvalid and awvalid right after reset -> write granted first, read next. A second simultaneous pair -> the channel not served last goes first.
- rready low 5 cycles during a 2-beat read -> rvalid/rdata held stable. Second beat is not issued to SRAM until the first handshake.
- Byte strobes: wstrb=0101 over 0xFFFFFFFF onto 0x00000000 -> readback 0x00FF00FF. wlast early on beat 0 of awlen=1 -> both beats written, bresp=10.
- aresetn low for one cycle in the middle of a 4-beat read -> rvalid=0 and FSM=IDLE next cycle. A new arvalid is accepted immediately after.
